// File: rtl/cook_pkg.sv
// cook_pkg: shared definitions for the microwave cook controller.
//   cook_state_t : FSM state encoding (IDLE, SET, COOK, PAUSE, DONE)
//   MODE_*       : power-mode codes driven to the LED master
//   REMAIN_W     : width of the remaining-time counter in seconds
//   next_mode    : power-mode rotation low -> normal -> high -> low
//   sat_add      : add with ceiling, used for every cook-time increment
package cook_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SET   = 3'd1,
    ST_COOK  = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } cook_state_t;

  localparam logic [1:0] MODE_LOW  = 2'b01;
  localparam logic [1:0] MODE_NORM = 2'b10;
  localparam logic [1:0] MODE_HIGH = 2'b11;

  localparam int unsigned REMAIN_W = 13;

  function automatic logic [1:0] next_mode(input logic [1:0] cur);
    logic [1:0] nxt;
    case (cur)
      MODE_LOW:  nxt = MODE_NORM;
      MODE_NORM: nxt = MODE_HIGH;
      MODE_HIGH: nxt = MODE_LOW;
      default:   nxt = MODE_NORM;
    endcase
    return nxt;
  endfunction

  // Sum is formed in 32 bits so the ceiling applies before any wrap.
  function automatic logic [REMAIN_W-1:0] sat_add(input logic [REMAIN_W-1:0] cur,
                                                  input int unsigned       add,
                                                  input int unsigned       max);
    int unsigned sum;
    sum = 32'(cur) + add;
    if (sum > max) sum = max;
    return sum[REMAIN_W-1:0];
  endfunction

endpackage

// File: rtl/cook_controller_sec_tick_gen.sv
// sec_tick_gen: one-second tick prescaler.
//   sys_clk : system clock
//   sys_rst : asynchronous active-low reset
//   en      : count enable; counter holds its value while low
//   clr     : synchronous clear to 0, dominates en
//   tick    : 1-cycle pulse in the enabled cycle where the count is TICK_DIV-1
module sec_tick_gen #(
  parameter int unsigned TICK_DIV = 100000000
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned      CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;

  assign tick = en && (cnt_q == LAST);

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/cook_controller.sv
// cook_controller: microwave cook-sequencing FSM feeding the LED display master.
//   sys_clk, sys_rst : clock, asynchronous active-low reset
//   btn_add          : pulse, add ADD_SEC seconds (saturating at MAX_SEC)
//   btn_mode         : pulse, rotate power mode (IDLE/SET only)
//   btn_start        : pulse, start or resume cooking (door must be closed)
//   btn_stop         : pulse, pause; from SET/PAUSE clears and returns to IDLE
//   door_open        : level, door sensor
//   start, idle      : state decodes for the LED master
//   mode             : power mode 01 low / 10 normal / 11 high
//   mini_rst         : 1-cycle pulse on each entry to COOK or IDLE
//   remain_sec       : remaining cook time in seconds
//   done             : high throughout DONE
// Button priority: stop > start > add > mode; only the highest pulse present acts.
module cook_controller
  import cook_pkg::*;
#(
  parameter int unsigned TICK_DIV = 100000000,
  parameter int unsigned ADD_SEC  = 30,
  parameter int unsigned MAX_SEC  = 5999,
  parameter int unsigned DONE_SEC = 3
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic                btn_add,
  input  logic                btn_mode,
  input  logic                btn_start,
  input  logic                btn_stop,
  input  logic                door_open,
  output logic                start,
  output logic                idle,
  output logic [1:0]          mode,
  output logic                mini_rst,
  output logic [REMAIN_W-1:0] remain_sec,
  output logic                done
);

  localparam int unsigned DC_W = (DONE_SEC > 1) ? $clog2(DONE_SEC + 1) : 1;

  cook_state_t         state_q, state_nx;
  logic [REMAIN_W-1:0] remain_q, remain_nx;
  logic [1:0]          mode_q, mode_nx;
  logic [DC_W-1:0]     done_cnt_q, done_cnt_nx;
  logic                tick_en, tick_clr, tick;

  sec_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .en      (tick_en),
    .clr     (tick_clr),
    .tick    (tick)
  );

  always_comb begin
    state_nx    = state_q;
    remain_nx   = remain_q;
    mode_nx     = mode_q;
    done_cnt_nx = done_cnt_q;
    tick_en     = 1'b0;
    tick_clr    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (btn_stop || btn_start) begin
          // no action in IDLE, but still masks lower-priority buttons
        end else if (btn_add) begin
          remain_nx = sat_add('0, ADD_SEC, MAX_SEC);
          state_nx  = ST_SET;
        end else if (btn_mode) begin
          mode_nx = next_mode(mode_q);
        end
      end

      ST_SET: begin
        if (btn_stop) begin
          remain_nx = '0;
          state_nx  = ST_IDLE;
        end else if (btn_start) begin
          if (!door_open) begin
            state_nx = ST_COOK;
            tick_clr = 1'b1;
          end
        end else if (btn_add) begin
          remain_nx = sat_add(remain_q, ADD_SEC, MAX_SEC);
        end else if (btn_mode) begin
          mode_nx = next_mode(mode_q);
        end
      end

      ST_COOK: begin
        // Pause freezes the prescaler in the same cycle so no partial second is lost.
        tick_en = !(door_open || btn_stop);
        if (door_open || btn_stop) begin
          state_nx = ST_PAUSE;
        end else if (btn_add && !btn_start) begin
          // Add wins over a coincident tick: no decrement, prescaler still wraps.
          remain_nx = sat_add(remain_q, ADD_SEC, MAX_SEC);
        end else if (tick) begin
          if (remain_q <= REMAIN_W'(1)) begin
            remain_nx   = '0;
            state_nx    = ST_DONE;
            tick_clr    = 1'b1;
            done_cnt_nx = '0;
          end else begin
            remain_nx = remain_q - REMAIN_W'(1);
          end
        end
      end

      ST_PAUSE: begin
        if (btn_stop) begin
          remain_nx = '0;
          state_nx  = ST_IDLE;
        end else if (btn_start) begin
          if (!door_open) state_nx = ST_COOK;
        end else if (btn_add) begin
          remain_nx = sat_add(remain_q, ADD_SEC, MAX_SEC);
        end
      end

      ST_DONE: begin
        tick_en = 1'b1;
        if (btn_stop || door_open) begin
          state_nx = ST_IDLE;
        end else if (tick) begin
          if (done_cnt_q == DC_W'(DONE_SEC - 1)) begin
            state_nx = ST_IDLE;
          end else begin
            done_cnt_nx = done_cnt_q + DC_W'(1);
          end
        end
      end

      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state_q    <= ST_IDLE;
      remain_q   <= '0;
      mode_q     <= MODE_NORM;
      done_cnt_q <= '0;
      start      <= 1'b0;
      idle       <= 1'b1;
      done       <= 1'b0;
      mini_rst   <= 1'b0;
    end else begin
      state_q    <= state_nx;
      remain_q   <= remain_nx;
      mode_q     <= mode_nx;
      done_cnt_q <= done_cnt_nx;
      start      <= (state_nx == ST_COOK);
      idle       <= (state_nx == ST_IDLE);
      done       <= (state_nx == ST_DONE);
      mini_rst   <= (state_nx != state_q) &&
                    ((state_nx == ST_COOK) || (state_nx == ST_IDLE));
    end
  end

  assign remain_sec = remain_q;
  assign mode       = mode_q;

endmodule

// File: doc/cook_controller.md
Name: cook_controller

Overview:
- Microwave cook-sequencing FSM sitting directly upstream of the LED display master.
- Accepts debounced single-cycle button pulses and a door sensor, holds the cook time and power mode, and counts the time down once per second.
- Drives the start / idle / mode / mini_rst strobes the LED master consumes, plus remaining-time and done outputs for the 7-segment and buzzer blocks.

Parameters:
- TICK_DIV, 100000000, sys_clk cycles per second tick (bench uses 4).
- ADD_SEC, 30, seconds added per btn_add press.
- MAX_SEC, 5999, cook-time ceiling (99:59).
- DONE_SEC, 3, seconds the done indication is held before returning to idle.

Ports:
- sys_clk  in  1  system clock.
- sys_rst  in  1  asynchronous, active-low reset.
- btn_add  in  1  1-cycle pulse: add ADD_SEC to cook time.
- btn_mode  in  1  1-cycle pulse: cycle power mode.
- btn_start  in  1  1-cycle pulse: start or resume cooking.
- btn_stop  in  1  1-cycle pulse: pause; a second press clears.
- door_open  in  1  level, 1 = door open.
- start  out  1  high while cooking (to LED master).
- idle  out  1  high in IDLE state (to LED master).
- mode  out  2  01 low, 10 normal, 11 high.
- mini_rst  out  1  1-cycle pulse restarting the LED pattern counter.
- remain_sec  out  13  remaining cook time in seconds.
- done  out  1  high throughout DONE state.

Behaviour:
- Reset values (sys_rst low, asynchronous): state IDLE, remain_sec 0, mode 2'b10, start 0, idle 1, mini_rst 0, done 0, prescaler 0.
- All outputs are registered. Outputs reflect the new state one cycle after the triggering pulse.
- States: IDLE, SET, COOK, PAUSE, DONE.
- IDLE:
  - btn_add sets remain_sec = ADD_SEC and goes to SET.
  - btn_mode cycles mode 01->10->11->01.
  - btn_start is ignored.
- SET:
  - btn_add: remain_sec = min(remain_sec + ADD_SEC, MAX_SEC). Saturates, never wraps.
  - btn_mode cycles mode.
  - btn_start with door closed goes to COOK; ignored with door open.
  - btn_stop clears remain_sec to 0 and goes to IDLE.
- COOK:
  - Prescaler counts 0..TICK_DIV-1. The tick fires at TICK_DIV-1, then the prescaler wraps to 0.
  - On each tick remain_sec decrements. If the tick occurs with remain_sec == 1, remain_sec becomes 0 and the state goes to DONE.
  - door_open high or btn_stop goes to PAUSE. The prescaler freezes; a second in progress is not lost.
  - btn_add: remain_sec = min(remain_sec + ADD_SEC, MAX_SEC).
  - btn_mode is ignored.
- PAUSE:
  - btn_start with door closed returns to COOK with the prescaler resumed.
  - btn_stop clears remain_sec and goes to IDLE.
  - btn_add is permitted and saturates as in SET.
- DONE:
  - done = 1, start = 0.
  - The prescaler runs; after DONE_SEC ticks the state goes to IDLE.
  - btn_stop or door_open goes to IDLE immediately.
  - Other buttons are ignored.
- Output decode:
  - start = (state == COOK).
  - idle = (state == IDLE).
  - done = (state == DONE).
- mini_rst: 1-cycle pulse on every entry to COOK (start or resume) and on every entry to IDLE. It is not pulsed at reset.
- Prescaler clears to 0 on entry to COOK from SET and on entry to DONE. It holds in PAUSE.
- Simultaneous events:
  - btn_stop beats btn_start, which beats btn_add, which beats btn_mode. Only the highest-priority pulse present acts.
  - In COOK, door_open or btn_stop beats a coincident tick: the state goes to PAUSE and remain_sec is not decremented.
  - btn_add coincident with the final tick: the add wins and the state stays in COOK. remain_sec = min(remain_sec + ADD_SEC, MAX_SEC) with no decrement that cycle, and the prescaler wraps.
- Reset mid-operation: state, timer, mode and prescaler return to reset values asynchronously. No mini_rst pulse is generated.

Decomposition:
- Shared package cook_pkg holds:
  - the state encoding (3-bit: IDLE=0, SET=1, COOK=2, PAUSE=3, DONE=4);
  - the mode constants MODE_LOW=2'b01, MODE_NORM=2'b10, MODE_HIGH=2'b11;
  - the remain_sec width 13.
- One sub-module, sec_tick_gen:
  - inputs: sys_clk, sys_rst, en, clr;
  - output: tick, a 1-cycle pulse every TICK_DIV enabled cycles;
  - parameterised by TICK_DIV.
- The FSM, timer register and output decode live in cook_controller.

Test Plan (TICK_DIV=4, ADD_SEC=30, DONE_SEC=3):
- Reset then idle -> idle=1, start=0, mode=10, remain_sec=0, no mini_rst pulse.
- btn_mode x3 in IDLE -> mode 11, 01, 10. btn_add x2 -> SET, remain_sec 60.
- remain_sec=30 via one add, btn_start -> mini_rst pulse, start=1, remain_sec 29 exactly 4 cycles later. After 120 cycles: remain_sec 0, done=1. After 12 further cycles: idle=1 with a mini_rst pulse.
- COOK with remain_sec 10, prescaler at 2: door_open for 20 cycles -> PAUSE, remain_sec stays 10. Close door, btn_start -> remain_sec 9 two cycles later.
- Saturation: btn_add x201 -> remain_sec stays 5999.
- btn_stop coincident with btn_start in SET -> IDLE, remain_sec 0. Assert sys_rst low mid-COOK -> all outputs at reset values in the same cycle.
